// File: rtl/misr_window_ctrl_if.sv
// Host-side bundle for misr_window_ctrl: window setup, datapath strobes and compare result.
// The master modport is the host/bench side; the slave modport is the controller.
interface misr_window_ctrl_if #(
  parameter int NUM_FF = 8,
  parameter int MISR_W = 3,
  parameter int CNT_W  = 8
);
  localparam int IDX_W = (NUM_FF > 1) ? $clog2(NUM_FF) : 1;

  logic              start_i;
  logic [CNT_W-1:0]  win_len_i;
  logic [MISR_W-1:0] golden_i;
  logic              inj_en_i;
  logic [IDX_W-1:0]  inj_idx_i;
  logic [CNT_W-1:0]  inj_cyc_i;
  logic [MISR_W-1:0] misr_sig_i;
  logic              clr_err_i;
  logic              misr_rst_o;
  logic [NUM_FF-1:0] inj_e_o;
  logic              busy_o;
  logic              done_o;
  logic              pass_o;
  logic [MISR_W-1:0] sig_o;
  logic              err_sticky_o;

  modport master (
    output start_i, win_len_i, golden_i, inj_en_i, inj_idx_i, inj_cyc_i,
           misr_sig_i, clr_err_i,
    input  misr_rst_o, inj_e_o, busy_o, done_o, pass_o, sig_o, err_sticky_o
  );

  modport slave (
    input  start_i, win_len_i, golden_i, inj_en_i, inj_idx_i, inj_cyc_i,
           misr_sig_i, clr_err_i,
    output misr_rst_o, inj_e_o, busy_o, done_o, pass_o, sig_o, err_sticky_o
  );
endinterface

// File: rtl/misr_window_ctrl.sv
// Sequences one MISR test window: clear, run with optional single-cycle FF injection, drain, compare.
// Optional sticky error flag is enabled by defining MISR_CTRL_STICKY_ERR_EN.
//
// state   | meaning
// S_IDLE  | waiting for start_i; window parameters latched on accept
// S_CLR   | one cycle of misr_rst_o
// S_RUN   | win_len cycles, r_cnt = 0..win_len-1, injection strobe possible
// S_DRAIN | DRAIN_CYC cycles letting the FF-to-MISR pipeline settle
// S_CMP   | one cycle: compare misr_sig_i to golden, done_o high
module misr_window_ctrl #(
  parameter int NUM_FF    = 8,
  parameter int MISR_W    = 3,
  parameter int CNT_W     = 8,
  parameter int DRAIN_CYC = 2
) (
  input logic              clk,
  input logic              rst_n,
  misr_window_ctrl_if.slave bus
);
  localparam int IDX_W = (NUM_FF > 1) ? $clog2(NUM_FF) : 1;
  localparam int DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DRN_W-1:0] DRN_INIT = DRN_W'(DRAIN_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_RUN, S_DRAIN, S_CMP} state_t;

  state_t            r_state;
  state_t            w_nxt;
  logic [CNT_W-1:0]  r_win_len;
  logic [MISR_W-1:0] r_golden;
  logic              r_inj_en;
  logic [IDX_W-1:0]  r_inj_idx;
  logic [CNT_W-1:0]  r_inj_cyc;
  logic [CNT_W-1:0]  r_cnt;
  logic [DRN_W-1:0]  r_drn;
  logic              r_pass;
  logic [MISR_W-1:0] r_sig;
  logic              w_cmp_pass;
  logic              w_misr_rst;
  logic              w_busy;
  logic              w_done;
  logic [NUM_FF-1:0] w_inj_e;

  assign w_cmp_pass = (bus.misr_sig_i == r_golden);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start_i) w_nxt = S_CLR;
      S_CLR:   w_nxt = (r_win_len == '0) ? S_DRAIN : S_RUN;
      S_RUN:   if (r_cnt == r_win_len - 1'b1) w_nxt = S_DRAIN;
      S_DRAIN: if (r_drn == '0) w_nxt = S_CMP;
      S_CMP:   w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // Injection target beyond NUM_FF or cycle beyond the window simply never matches.
  always_comb begin
    w_misr_rst = (r_state == S_CLR);
    w_busy     = (r_state != S_IDLE);
    w_done     = (r_state == S_CMP);
    w_inj_e    = '0;
    if ((r_state == S_RUN) && r_inj_en && (r_cnt == r_inj_cyc) &&
        ({1'b0, r_inj_idx} < (IDX_W+1)'(NUM_FF)))
      w_inj_e[r_inj_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_len <= '0;
      r_golden  <= '0;
      r_inj_en  <= 1'b0;
      r_inj_idx <= '0;
      r_inj_cyc <= '0;
      r_cnt     <= '0;
      r_drn     <= '0;
      r_pass    <= 1'b0;
      r_sig     <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start_i) begin
          r_win_len <= bus.win_len_i;
          r_golden  <= bus.golden_i;
          r_inj_en  <= bus.inj_en_i;
          r_inj_idx <= bus.inj_idx_i;
          r_inj_cyc <= bus.inj_cyc_i;
          r_cnt     <= '0;
        end
        S_CLR: begin
          r_cnt <= '0;
          r_drn <= DRN_INIT;
        end
        S_RUN:   r_cnt <= r_cnt + 1'b1;
        S_DRAIN: r_drn <= r_drn - 1'b1;
        S_CMP: begin
          r_pass <= w_cmp_pass;
          r_sig  <= bus.misr_sig_i;
        end
        default: ;
      endcase
    end
  end

  assign bus.misr_rst_o = w_misr_rst;
  assign bus.inj_e_o    = w_inj_e;
  assign bus.busy_o     = w_busy;
  assign bus.done_o     = w_done;
  // Result is live during the done cycle and held from the register afterwards.
  assign bus.pass_o     = w_done ? w_cmp_pass : r_pass;
  assign bus.sig_o      = w_done ? bus.misr_sig_i : r_sig;

`ifdef MISR_CTRL_STICKY_ERR_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_err <= 1'b0;
    else if (w_done && !w_cmp_pass) r_err <= 1'b1;
    else if (bus.clr_err_i)        r_err <= 1'b0;
  end

  assign bus.err_sticky_o = r_err;
`else
  logic w_unused_clr_err;

  assign w_unused_clr_err = bus.clr_err_i;
  assign bus.err_sticky_o = 1'b0;
`endif
endmodule

// File: tb/tb_misr_window_ctrl.sv
// Directed bench for misr_window_ctrl: table of full windows plus hand-written reset and restart sequences.
// Sticky-flag expectations follow MISR_CTRL_STICKY_ERR_EN.
module tb_misr_window_ctrl;
  localparam int NUM_FF    = 8;
  localparam int MISR_W    = 3;
  localparam int CNT_W     = 8;
  localparam int DRAIN_CYC = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  logic exp_err = 1'b0;

  misr_window_ctrl_if #(.NUM_FF(NUM_FF), .MISR_W(MISR_W), .CNT_W(CNT_W)) bus ();

  misr_window_ctrl #(.NUM_FF(NUM_FF), .MISR_W(MISR_W), .CNT_W(CNT_W), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] win_len;
    logic [2:0] golden;
    logic       inj_en;
    logic [2:0] inj_idx;
    logic [7:0] inj_cyc;
    logic [2:0] misr_sig;
    logic       busy_pulse;
    logic       clr_at_done;
    int         exp_done;
    int         exp_inj_at;
    logic [7:0] exp_inj_val;
    logic       exp_pass;
  } win_vec_t;

  win_vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive_window(input win_vec_t v);
    bus.start_i    = 1'b1;
    bus.win_len_i  = v.win_len;
    bus.golden_i   = v.golden;
    bus.inj_en_i   = v.inj_en;
    bus.inj_idx_i  = v.inj_idx;
    bus.inj_cyc_i  = v.inj_cyc;
    bus.misr_sig_i = v.misr_sig;
  endtask

  task automatic run_window(input win_vec_t v, input string tag);
    int         k;
    int         rst_cnt;
    int         rst_first;
    int         inj_cnt;
    int         inj_first;
    int         done_at;
    logic [7:0] inj_val;
    logic       viol;
    logic       pass_at;
    logic [2:0] sig_at;
    rst_cnt = 0; rst_first = -1; inj_cnt = 0; inj_first = -1; done_at = -1;
    inj_val = '0; viol = 1'b0; pass_at = 1'b0; sig_at = '0;
    @(posedge clk); #1;
    drive_window(v);
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    // Latched copies must be used from here on: scramble the live setup inputs.
    bus.golden_i  = ~v.golden;
    bus.win_len_i = v.win_len + 8'd3;
    bus.inj_en_i  = ~v.inj_en;
    bus.inj_idx_i = v.inj_idx ^ 3'd1;
    bus.inj_cyc_i = 8'd0;
    k = 1;
    while (k < 300 && done_at < 0) begin
      bus.clr_err_i = (v.clr_at_done && k == v.exp_done);
      bus.start_i   = (v.busy_pulse && k == 2);
      @(negedge clk);
      if (bus.misr_rst_o) begin
        rst_cnt++;
        if (rst_first < 0) rst_first = k;
      end
      if (bus.inj_e_o != '0) begin
        inj_cnt++;
        inj_first = k;
        inj_val   = bus.inj_e_o;
      end
      if ($countones(bus.inj_e_o) > 1) viol = 1'b1;
      if (bus.misr_rst_o && bus.inj_e_o != '0) viol = 1'b1;
      if (!bus.busy_o) viol = 1'b1;
      if (bus.done_o) begin
        done_at = k;
        pass_at = bus.pass_o;
        sig_at  = bus.sig_o;
      end else begin
        @(posedge clk); #1;
        k++;
      end
    end
    chk({tag, " done_latency"}, done_at, v.exp_done);
    chk({tag, " misr_rst_count"}, rst_cnt, 1);
    chk({tag, " misr_rst_cycle"}, rst_first, 1);
    chk({tag, " inj_count"}, inj_cnt, (v.exp_inj_at >= 0) ? 1 : 0);
    chk({tag, " inj_cycle"}, inj_first, v.exp_inj_at);
    chk({tag, " inj_value"}, inj_val, v.exp_inj_val);
    chk({tag, " pass_at_done"}, pass_at, v.exp_pass);
    chk({tag, " sig_at_done"}, sig_at, v.misr_sig);
    chk({tag, " invariants"}, viol, 1'b0);
    @(posedge clk); #1;
    bus.clr_err_i  = 1'b0;
    bus.start_i    = 1'b0;
    bus.misr_sig_i = ~v.misr_sig;
    @(negedge clk);
`ifdef MISR_CTRL_STICKY_ERR_EN
    if (!v.exp_pass) exp_err = 1'b1;
    else if (v.clr_at_done) exp_err = 1'b0;
`endif
    chk({tag, " busy_after"}, bus.busy_o, 1'b0);
    chk({tag, " done_pulse_width"}, bus.done_o, 1'b0);
    chk({tag, " pass_held"}, bus.pass_o, v.exp_pass);
    chk({tag, " sig_held"}, bus.sig_o, v.misr_sig);
    chk({tag, " err_sticky"}, bus.err_sticky_o, exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    //          len   gold  en    idx   cyc   sig   pls   clr   done inj  injv   pass
    vecs[0] = '{8'd4, 3'd3, 1'b0, 3'd0, 8'd0, 3'd3, 1'b0, 1'b0, 8,   -1,  8'h00, 1'b1};
    vecs[1] = '{8'd6, 3'd3, 1'b1, 3'd3, 8'd2, 3'd4, 1'b0, 1'b0, 10,  4,   8'h08, 1'b0};
    vecs[2] = '{8'd3, 3'd5, 1'b1, 3'd6, 8'd5, 3'd5, 1'b0, 1'b0, 7,   -1,  8'h00, 1'b1};
    vecs[3] = '{8'd0, 3'd2, 1'b1, 3'd1, 8'd0, 3'd2, 1'b1, 1'b0, 4,   -1,  8'h00, 1'b1};
    vecs[4] = '{8'd1, 3'd6, 1'b1, 3'd7, 8'd0, 3'd6, 1'b1, 1'b0, 5,   2,   8'h80, 1'b1};
    vecs[5] = '{8'd5, 3'd1, 1'b1, 3'd0, 8'd4, 3'd0, 1'b0, 1'b1, 9,   6,   8'h01, 1'b0};

    rst_n = 1'b0;
    bus.start_i = 1'b0; bus.win_len_i = '0; bus.golden_i = '0; bus.inj_en_i = 1'b0;
    bus.inj_idx_i = '0; bus.inj_cyc_i = '0; bus.misr_sig_i = '0; bus.clr_err_i = 1'b0;
    #1;
    chk("reset busy", bus.busy_o, 1'b0);
    chk("reset done", bus.done_o, 1'b0);
    chk("reset misr_rst", bus.misr_rst_o, 1'b0);
    chk("reset inj_e", bus.inj_e_o, 8'h00);
    chk("reset pass", bus.pass_o, 1'b0);
    chk("reset sig", bus.sig_o, 3'd0);
    chk("reset err", bus.err_sticky_o, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_window(vecs[i], $sformatf("vec%0d", i));

    // Explicit clear of the sticky flag.
    @(posedge clk); #1 bus.clr_err_i = 1'b1;
    @(posedge clk); #1 bus.clr_err_i = 1'b0;
    @(negedge clk);
    chk("clr_err result", bus.err_sticky_o, 1'b0);

    // start_i high only in the CMP cycle is ignored.
    @(posedge clk); #1;
    drive_window('{8'd2, 3'd0, 1'b0, 3'd0, 8'd0, 3'd0, 1'b0, 1'b0, 6, -1, 8'h00, 1'b1});
    @(posedge clk); #1 bus.start_i = 1'b0;
    repeat (5) @(posedge clk);
    #1 bus.start_i = 1'b1;
    @(negedge clk);
    chk("cmp_restart done", bus.done_o, 1'b1);
    @(posedge clk); #1 bus.start_i = 1'b0;
    @(negedge clk);
    chk("cmp_restart idle1", bus.busy_o, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("cmp_restart idle2", bus.busy_o, 1'b0);
    chk("cmp_restart no_clr", bus.misr_rst_o, 1'b0);

    // start_i held through CMP and the next cycle is accepted one cycle after done_o.
    @(posedge clk); #1;
    drive_window('{8'd2, 3'd0, 1'b0, 3'd0, 8'd0, 3'd0, 1'b0, 1'b0, 6, -1, 8'h00, 1'b1});
    @(posedge clk); #1 bus.start_i = 1'b0;
    repeat (5) @(posedge clk);
    #1 bus.start_i = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("restart idle_accept", bus.busy_o, 1'b0);
    @(posedge clk); #1 bus.start_i = 1'b0;
    @(negedge clk);
    chk("restart clr", bus.misr_rst_o, 1'b1);
    begin
      int n;
      n = 0;
      while (!bus.done_o && n < 50) begin
        @(posedge clk); #1;
        @(negedge clk);
        n++;
      end
      chk("restart window_done", bus.done_o, 1'b1);
    end

    // Reset during CLR drops misr_rst_o asynchronously.
    @(posedge clk); #1;
    drive_window('{8'd6, 3'd5, 1'b1, 3'd3, 8'd2, 3'd5, 1'b0, 1'b0, 10, 4, 8'h08, 1'b1});
    @(posedge clk); #1 bus.start_i = 1'b0;
    @(negedge clk);
    chk("rst_clr before", bus.misr_rst_o, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_clr misr_rst", bus.misr_rst_o, 1'b0);
    chk("rst_clr busy", bus.busy_o, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Reset mid-RUN with counter==2, exactly where the strobe is active.
    @(posedge clk); #1;
    drive_window('{8'd6, 3'd5, 1'b1, 3'd3, 8'd2, 3'd5, 1'b0, 1'b0, 10, 4, 8'h08, 1'b1});
    repeat (4) begin
      @(posedge clk); #1 bus.start_i = 1'b0;
    end
    @(negedge clk);
    chk("rst_run inj_before", bus.inj_e_o, 8'h08);
    chk("rst_run busy_before", bus.busy_o, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_run busy", bus.busy_o, 1'b0);
    chk("rst_run inj_e", bus.inj_e_o, 8'h00);
    chk("rst_run misr_rst", bus.misr_rst_o, 1'b0);
    chk("rst_run sig_cleared", bus.sig_o, 3'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_run idle_after", bus.busy_o, 1'b0);
    chk("rst_run done_after", bus.done_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
